// File: rtl/credit_arbiter.sv
// Per-channel credit counters with a round-robin pop arbiter feeding one shared downstream link.
// Credit returns saturate at N_CREDITS, and any overflow sets a sticky per-channel flag.
module credit_arbiter #(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned N_CREDITS  = 10,
    parameter int unsigned RET_WIDTH  = 2,
    localparam int unsigned CW  = $clog2(N_CREDITS + 2**RET_WIDTH) + 1,
    localparam int unsigned CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_CHANNELS-1:0]           i_fifo_empty,
    output logic [N_CHANNELS-1:0]           o_pop,
    output logic                            o_valid,
    output logic [CHW-1:0]                  o_chan,
    input  logic [N_CHANNELS*RET_WIDTH-1:0] i_credit_ret,
    output logic [N_CHANNELS-1:0]           o_ready,
    output logic [N_CHANNELS*CW-1:0]        o_credits,
    output logic [N_CHANNELS-1:0]           o_overflow
);

    logic [CW-1:0]         count_q [N_CHANNELS];
    logic [CW-1:0]         count_d [N_CHANNELS];
    logic [CW-1:0]         sum_c   [N_CHANNELS];
    logic [N_CHANNELS-1:0] overflow_q, overflow_d;
    logic [CHW-1:0]        last_grant_q, last_grant_d;
    logic [CHW-1:0]        chan_q, chan_d;
    logic                  valid_q, valid_d;
    logic [N_CHANNELS-1:0] eligible_c;
    logic [N_CHANNELS-1:0] pop_c;
    logic                  grant_c;
    logic [CHW-1:0]        grant_idx_c;

    function automatic logic [CHW-1:0] rr_index(input logic [CHW-1:0] base, input int unsigned off);
        return CHW'((32'(base) + off) % N_CHANNELS);
    endfunction

    // Eligibility looks only at the registered count; same-cycle returns do not count.
    always_comb begin
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            eligible_c[c] = !i_fifo_empty[c] && (count_q[c] != '0);
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        pop_c       = '0;
        grant_c     = 1'b0;
        grant_idx_c = '0;
        for (int unsigned off = 1; off <= N_CHANNELS; off++) begin
            if (!grant_c && eligible_c[rr_index(last_grant_q, off)]) begin
                grant_c     = 1'b1;
                grant_idx_c = rr_index(last_grant_q, off);
            end
        end
        if (reset) begin
            grant_c = 1'b0;
        end
        if (grant_c) begin
            pop_c[grant_idx_c] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            sum_c[c]      = count_q[c] - CW'(pop_c[c]) + CW'(i_credit_ret[c*RET_WIDTH +: RET_WIDTH]);
            count_d[c]    = sum_c[c];
            overflow_d[c] = overflow_q[c];
            if (sum_c[c] > CW'(N_CREDITS)) begin
                count_d[c]    = CW'(N_CREDITS);
                overflow_d[c] = 1'b1;
            end
        end
        last_grant_d = grant_c ? grant_idx_c : last_grant_q;
        valid_d      = grant_c;
        chan_d       = grant_c ? grant_idx_c : chan_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                count_q[c] <= CW'(N_CREDITS);
            end
            overflow_q   <= '0;
            last_grant_q <= CHW'(N_CHANNELS - 1);
            valid_q      <= 1'b0;
            chan_q       <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                count_q[c] <= count_d[c];
            end
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
            chan_q       <= chan_d;
        end
    end

    assign o_pop      = pop_c;
    assign o_valid    = valid_q;
    assign o_chan     = chan_q;
    assign o_overflow = overflow_q;

    always_comb begin
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            o_ready[c]            = !reset && (count_q[c] != '0);
            o_credits[c*CW +: CW] = count_q[c];
        end
    end

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter: an integer-level model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_credit_arbiter;

    localparam int N  = 4;
    localparam int NC = 10;
    localparam int CW = 5;

    logic          clock;
    logic          reset;
    logic [3:0]    i_fifo_empty;
    logic [3:0]    o_pop;
    logic          o_valid;
    logic [1:0]    o_chan;
    logic [7:0]    i_credit_ret;
    logic [3:0]    o_ready;
    logic [19:0]   o_credits;
    logic [3:0]    o_overflow;

    credit_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .i_fifo_empty (i_fifo_empty),
        .o_pop        (o_pop),
        .o_valid      (o_valid),
        .o_chan       (o_chan),
        .i_credit_ret (i_credit_ret),
        .o_ready      (o_ready),
        .o_credits    (o_credits),
        .o_overflow   (o_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state
    int       m_cnt [N];
    logic [3:0] m_ov;
    int       m_lg;
    logic     m_valid;
    int       m_chan;
    bit       m_init = 1'b0;

    // Values observed mid-cycle by the last step
    logic [3:0]  cap_pop;
    logic [3:0]  cap_ready;
    logic [19:0] cap_credits;
    logic [3:0]  cap_ov;
    logic        cap_valid;
    logic [1:0]  cap_chan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        if ($countones(v) != 1) r = -1;
        return r;
    endfunction

    function automatic logic [31:0] cred(input logic [19:0] v, input int c);
        logic [4:0] f;
        f = v[c*CW +: CW];
        return 32'(f);
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic rst, input logic [3:0] empty, input logic [7:0] ret);
        int g;
        int s;
        logic [3:0] exp_pop;
        logic [3:0] exp_ready;
        reset        = rst;
        i_fifo_empty = empty;
        i_credit_ret = ret;
        @(negedge clock);
        cap_pop     = o_pop;
        cap_ready   = o_ready;
        cap_credits = o_credits;
        cap_ov      = o_overflow;
        cap_valid   = o_valid;
        cap_chan    = o_chan;

        g = -1;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_lg + k) % N;
                if (g < 0 && !empty[c] && m_cnt[c] != 0) g = c;
            end
        end
        exp_pop   = 4'b0;
        exp_ready = 4'b0;
        if (g >= 0) exp_pop[g] = 1'b1;
        if (!rst) begin
            for (int c = 0; c < N; c++) exp_ready[c] = (m_cnt[c] != 0);
        end
        check("pop", 32'(cap_pop), 32'(exp_pop));
        check("ready", 32'(cap_ready), 32'(exp_ready));
        if (m_init) begin
            check("valid", 32'(cap_valid), 32'(m_valid));
            if (m_valid) check("chan", 32'(cap_chan), 32'(m_chan));
            for (int c = 0; c < N; c++) check("credits", cred(cap_credits, c), 32'(m_cnt[c]));
            check("overflow", 32'(cap_ov), 32'(m_ov));
        end

        @(posedge clock);
        if (rst) begin
            for (int c = 0; c < N; c++) m_cnt[c] = NC;
            m_ov    = 4'b0;
            m_lg    = N - 1;
            m_valid = 1'b0;
            m_chan  = 0;
            m_init  = 1'b1;
        end else begin
            for (int c = 0; c < N; c++) begin
                s = m_cnt[c] - ((g == c) ? 1 : 0) + int'(ret[c*2 +: 2]);
                if (s > NC) begin
                    m_cnt[c] = NC;
                    m_ov[c]  = 1'b1;
                end else begin
                    m_cnt[c] = s;
                end
            end
            if (g >= 0) begin
                m_lg    = g;
                m_valid = 1'b1;
                m_chan  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    int npops;
    int seq [13];
    int exp_rr [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2};
    logic [19:0] all10;

    initial begin
        all10 = {4{5'd10}};

        // Reset with all FIFOs non-empty and returns present
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 8'hFF);

        // Single-channel drain on channel 2
        step(1'b0, 4'b1011, 8'h00);
        check("pin_reset_credits", 32'(cap_credits), 32'(all10));
        check("pin_reset_ready", 32'(cap_ready), 32'h0000_000F);
        check("pin_reset_ovf", 32'(cap_ov), 32'h0);
        npops = (cap_pop == 4'b0100) ? 1 : 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 4'b1011, 8'h00);
            if (cap_pop == 4'b0100) npops++;
        end
        check("pin_drain_pops", 32'(npops), 32'd10);
        check("pin_drain_ready", 32'(cap_ready), 32'h0000_000B);
        check("pin_drain_cnt2", cred(cap_credits, 2), 32'd0);
        step(1'b0, 4'b1011, 8'h10);
        check("pin_ret_same_cycle_pop", 32'(cap_pop), 32'h0);
        step(1'b0, 4'b1011, 8'h00);
        check("pin_ret_pop", 32'(cap_pop), 32'h4);
        check("pin_ret_cnt2", cred(cap_credits, 2), 32'd1);
        step(1'b0, 4'b1011, 8'h00);
        check("pin_ret_nopop", 32'(cap_pop), 32'h0);
        check("pin_ret_valid", 32'(cap_valid), 32'h1);
        check("pin_ret_chan", 32'(cap_chan), 32'h2);

        // Round-robin from a fresh reset, then with channel 1 empty
        step(1'b1, 4'b1111, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0000, 8'h00);
            seq[i] = onehot_idx(cap_pop);
        end
        for (int i = 8; i < 13; i++) begin
            step(1'b0, 4'b0010, 8'h00);
            seq[i] = onehot_idx(cap_pop);
        end
        for (int i = 0; i < 13; i++) check("pin_rr_order", 32'(seq[i]), 32'(exp_rr[i]));

        // Grant and return together on channel 0 at count 5
        step(1'b0, 4'b1110, 8'h00);
        step(1'b0, 4'b1110, 8'h03);
        check("pin_gr_pop", 32'(cap_pop), 32'h1);
        check("pin_gr_before", cred(cap_credits, 0), 32'd5);
        step(1'b0, 4'b1111, 8'h00);
        check("pin_gr_after", cred(cap_credits, 0), 32'd7);

        // Overflow on channel 3 from count 9
        step(1'b0, 4'b1111, 8'h80);
        step(1'b0, 4'b1111, 8'hC0);
        check("pin_ovf_before", cred(cap_credits, 3), 32'd9);
        step(1'b0, 4'b1111, 8'h00);
        check("pin_ovf_sat", cred(cap_credits, 3), 32'd10);
        check("pin_ovf_flag", 32'(cap_ov), 32'h8);
        step(1'b0, 4'b0111, 8'h00);
        step(1'b0, 4'b0111, 8'h00);
        step(1'b0, 4'b1111, 8'h00);
        check("pin_ovf_sticky", 32'(cap_ov), 32'h8);
        check("pin_ovf_popped", cred(cap_credits, 3), 32'd8);

        // Reset mid-stream with channel 1 at count 2 and o_valid high
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1101, 8'h00);
        step(1'b1, 4'b1111, 8'h00);
        check("pin_mid_valid", 32'(cap_valid), 32'h1);
        check("pin_mid_chan", 32'(cap_chan), 32'h1);
        check("pin_mid_cnt1", cred(cap_credits, 1), 32'd2);
        step(1'b0, 4'b0000, 8'h00);
        check("pin_mid_valid_drop", 32'(cap_valid), 32'h0);
        check("pin_mid_credits", 32'(cap_credits), 32'(all10));
        check("pin_mid_restart", 32'(cap_pop), 32'h1);
        check("pin_mid_ovf_clr", 32'(cap_ov), 32'h0);
        step(1'b0, 4'b1111, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/credit_arbiter.md
# credit_arbiter

Multi-channel credit-based flow-control unit for the latency-insensitive shell. It tracks a credit counter per channel and arbitrates round-robin among channels that have both a non-empty input FIFO and at least one credit. It issues at most one FIFO pop per cycle onto a shared downstream link. Credit returns are multi-credit per cycle, counters saturate, and any credit overflow is latched per channel as a sticky error.

## Interface
- N_CHANNELS, 4, number of independent channels (≥1).
- N_CREDITS, 10, credits per channel after reset; equals the downstream buffer depth.
- RET_WIDTH, 2, width of each channel's credit-return field; max return is 2^RET_WIDTH−1 per cycle.
- CW (localparam), $clog2(N_CREDITS + 2^RET_WIDTH) + 1, counter width; holds the pre-saturation sum.
- CHW (localparam), max($clog2(N_CHANNELS),1), channel-id width.

- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- i_fifo_empty  in  N_CHANNELS  per-channel upstream FIFO empty flag.
- o_pop  out  N_CHANNELS  one-hot (or zero) combinational pop to upstream FIFOs; show-ahead FIFO read.
- o_valid  out  1  registered; downstream word valid this cycle.
- o_chan  out  CHW  registered; channel id of the word qualified by o_valid.
- i_credit_ret  in  N_CHANNELS*RET_WIDTH  credits returned per channel this cycle; channel c in bits [c*RET_WIDTH +: RET_WIDTH].
- o_ready  out  N_CHANNELS  per-channel credit-available flag (count ≠ 0).
- o_credits  out  N_CHANNELS*CW  current counter values; channel c in [c*CW +: CW].
- o_overflow  out  N_CHANNELS  sticky; set when a return pushed the count above N_CREDITS.

## Operation
- eligible[c] = !i_fifo_empty[c] && count[c] != 0. Uses the registered count only; a return in the same cycle does not create eligibility.
- Round-robin: search starts at channel last_grant+1 (mod N_CHANNELS). The first eligible channel wins: o_pop[c] = 1 in the same cycle. If no channel is eligible, o_pop = 0.
- last_grant updates only on a grant.
- Counter update per channel: sum = count − (o_pop[c] ? 1 : 0) + ret[c], computed at CW bits.
  - If sum > N_CREDITS: count ← N_CREDITS and o_overflow[c] ← 1.
  - Otherwise count ← sum.
- Grant and return on the same channel in the same cycle are both applied (net ret−1).
- Underflow cannot occur, because a grant requires count ≠ 0.
- o_ready[c] = (count[c] != 0), driven from the register and forced to 0 while reset is high.
- o_overflow clears only on reset.

## Timing
- Reset values: count = N_CREDITS on all channels; last_grant = N_CHANNELS−1, so channel 0 is searched first; o_pop = 0 (forced while reset is high); o_valid = 0; o_chan = 0; o_overflow = 0; o_ready = 0 during reset, and all 1 in the first cycle after reset deasserts.
- Pop-to-valid latency is 1 cycle: a pop at cycle t produces o_valid = 1 and o_chan = c at t+1. Downstream samples the FIFO data muxed by o_chan at t+1.
- Throughput is 1 grant per cycle total. With k channels continuously eligible, each channel gets exactly 1 grant every k cycles.
- A credit returned at cycle t is visible in count, o_ready and o_credits at t+1. It can enable a grant at t+1.
- A channel whose count reaches 0 at edge t is not granted at t or later until a return is applied.
- A reset asserted mid-stream takes effect at the next edge:
  - counts are restored to N_CREDITS and o_overflow is cleared;
  - any in-flight o_valid is dropped (0 at the edge after reset is sampled);
  - credits still in flight downstream are discarded. Downstream is reset together with this block.
- Returns presented while reset is high are ignored.

## Test plan
- Reset check: hold reset 3 cycles with all FIFOs non-empty and nonzero returns.
  - During reset: o_pop = 0, o_valid = 0, o_ready = 0.
  - After release: o_credits = 10 on every channel, o_ready = 4'b1111, o_overflow = 0.
- Single-channel drain: only channel 2 non-empty, no returns.
  - 10 consecutive pops on channel 2; o_valid/o_chan = 2 one cycle after each pop.
  - Then o_ready[2] = 0 and no further pops.
  - Returning 1 credit restores exactly 1 pop, on the following cycle.
- Round-robin: all 4 channels non-empty.
  - Pop order is 0,1,2,3,0,1,2,3…
  - Making channel 1 empty mid-sequence yields the order …0,2,3,0,2…
- Simultaneous grant and return: channel 0 at count 5 popped with ret = 3 in the same cycle → count = 7 next cycle.
- Overflow: channel 3 at count 9, not popped, ret = 3 → count = 10 and o_overflow[3] = 1. The flag stays set after later pops, until reset.
- Reset mid-operation: with channel 1 at count 2 and o_valid high, assert reset for 1 cycle.
  - o_valid goes to 0 at the next edge.
  - After release: count = 10 and round-robin restarts at channel 0.
